// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET return sequencer.
// Owns mepc/mcause/mtval/mtvec and mstatus.MIE/MPIE; redirects fetch.
module trap_sequencer #(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
  parameter bit          VECTOR_EN   = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        excPresent_i,
  input  logic [31:0] excCause_i,
  input  logic [31:0] trapInfo_i,
  input  logic [31:0] pc_i,
  input  logic        mret_i,
  input  logic        csrWe_i,
  input  logic [11:0] csrAddr_i,
  input  logic [31:0] csrWdata_i,
  output logic [31:0] csrRdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        pcRedirect_o,
  output logic [31:0] pcTarget_o,
  output logic        mie_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAVE,
    S_JUMP,
    S_RET
  } state_t;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;
  localparam logic [11:0] A_MTVAL   = 12'h343;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] r_mtvec;
  logic        r_mie;
  logic        r_mpie;
  logic [29:0] r_hpc;
  logic [31:0] r_hcause;
  logic [31:0] r_hinfo;

  logic        w_idle;
  logic        w_accept;
  logic        w_mret;
  logic        w_csr;
  logic [31:0] w_base;
  logic [31:0] w_vec;
  logic        w_vec_en;

  assign w_idle   = (r_state == S_IDLE);
  // Interrupts are masked by MIE; synchronous exceptions never are.
  assign w_accept = w_idle & excPresent_i
                  & (~excCause_i[31] | r_mie);
  assign w_mret   = w_idle & ~w_accept & mret_i;
  assign w_csr    = w_idle & ~w_accept & ~mret_i & csrWe_i;

  assign w_base   = {r_mtvec[31:2], 2'b00};
  assign w_vec    = w_base + {25'd0, r_mcause[4:0], 2'b00};
  assign w_vec_en = VECTOR_EN & (r_mtvec[1:0] == 2'b01)
                  & r_mcause[31];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    pcRedirect_o = 1'b0;
    pcTarget_o   = 32'd0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = S_SAVE;
        end else if (w_mret) begin
          w_next = S_RET;
        end
      end
      S_SAVE: begin
        stall_o = 1'b1;
        flush_o = 1'b1;
        w_next  = S_JUMP;
      end
      S_JUMP: begin
        stall_o      = 1'b1;
        pcRedirect_o = 1'b1;
        pcTarget_o   = w_vec_en ? w_vec : w_base;
        w_next       = S_IDLE;
      end
      S_RET: begin
        stall_o      = 1'b1;
        pcRedirect_o = 1'b1;
        pcTarget_o   = r_mepc;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hpc    <= '0;
      r_hcause <= '0;
      r_hinfo  <= '0;
    end else if (w_accept) begin
      r_hpc    <= pc_i[31:2];
      r_hcause <= excCause_i;
      r_hinfo  <= trapInfo_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_mepc   <= '0;
      r_mcause <= '0;
      r_mtval  <= '0;
      r_mtvec  <= RESET_MTVEC;
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
    end else if (r_state == S_SAVE) begin
      r_mepc   <= {r_hpc, 2'b00};
      r_mcause <= r_hcause;
      r_mtval  <= r_hinfo;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (w_mret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (w_csr) begin
      unique case (csrAddr_i)
        A_MSTATUS: begin
          r_mie  <= csrWdata_i[3];
          r_mpie <= csrWdata_i[7];
        end
        // Reserved MODE values 2/3 fall back to direct.
        A_MTVEC:  r_mtvec  <= csrWdata_i[1] ?
                              {csrWdata_i[31:2], 2'b00} :
                              csrWdata_i;
        A_MEPC:   r_mepc   <= {csrWdata_i[31:2], 2'b00};
        A_MCAUSE: r_mcause <= csrWdata_i;
        A_MTVAL:  r_mtval  <= csrWdata_i;
        default: ;
      endcase
    end
  end

  always_comb begin
    csrRdata_o = 32'd0;
    unique case (csrAddr_i)
      A_MSTATUS: csrRdata_o = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      A_MTVEC:   csrRdata_o = r_mtvec;
      A_MEPC:    csrRdata_o = r_mepc;
      A_MCAUSE:  csrRdata_o = r_mcause;
      A_MTVAL:   csrRdata_o = r_mtval;
      default:   csrRdata_o = 32'd0;
    endcase
  end

  assign mie_o = r_mie;

endmodule
